// File: rtl/router_pkg.sv
// Shared definitions for the packet router controller.
// Holds the 4-bit FSM state encoding used by router_ctrl_np.
package router_pkg;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    WAIT_TILL_EMPTY    = 4'd1,
    LOAD_FIRST_DATA    = 4'd2,
    LOAD_DATA          = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    LOAD_PARITY        = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

endpackage

// File: rtl/router_timeout.sv
// Per-port idle-read watchdog: counts cycles with data pending and no read.
// Ports: clock, resetn (sync, active-low), vld, read, empty in; soft_reset out.
module router_timeout #(
  parameter int TIMEOUT = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic read,
  input  logic empty,
  output logic soft_reset
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= 1'b0;
      if (read || empty) begin
        cnt <= '0;
      end else if (vld) begin
        // TIMEOUT-th idle cycle fires the flush and restarts the count
        if (cnt == CW'(TIMEOUT - 1)) begin
          cnt        <= '0;
          soft_reset <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/router_ctrl_np.sv
// Router controller: decodes header, steers bytes to a port FIFO, checks parity.
// Ports: clock/resetn, packet_valid, data_in, fifo_* status, read_enb in;
// write_enb, data_out, busy, err, parity_done, vld_out, soft_reset out.
module router_ctrl_np
  import router_pkg::*;
#(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 30
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  packet_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [NUM_PORTS-1:0]  fifo_full,
  input  logic [NUM_PORTS-1:0]  fifo_empty,
  input  logic [NUM_PORTS-1:0]  read_enb,
  output logic [NUM_PORTS-1:0]  write_enb,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  err,
  output logic                  parity_done,
  output logic [NUM_PORTS-1:0]  vld_out,
  output logic [NUM_PORTS-1:0]  soft_reset
);

  localparam int ADDR_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int PW     = 1 << ADDR_W;

  state_t state, nxt;

  logic [ADDR_W-1:0]     port, addr;
  logic [DATA_WIDTH-1:0] header, hold, par, rx_par;
  logic                  hold_par;
  logic [PW-1:0]         full_x, empty_x, sr_x, we_x;
  logic                  addr_ok, hdr_ok, in_flight, abort;
  logic                  p_full, p_empty, wr, wr_q;

  // Pad per-port vectors to a power of two so any address indexes safely
  always_comb begin
    full_x  = '0;
    empty_x = '0;
    sr_x    = '0;
    full_x[NUM_PORTS-1:0]  = fifo_full;
    empty_x[NUM_PORTS-1:0] = fifo_empty;
    sr_x[NUM_PORTS-1:0]    = soft_reset;
  end

  assign addr      = data_in[ADDR_W-1:0];
  assign addr_ok   = (int'(addr) < NUM_PORTS);
  assign hdr_ok    = (state == DECODE_ADDRESS) && packet_valid && addr_ok;
  assign in_flight = (state != DECODE_ADDRESS) && (state != DROP_PACKET);
  assign abort     = in_flight && sr_x[port];
  assign p_full    = full_x[port];
  assign p_empty   = empty_x[port];
  assign vld_out   = ~fifo_empty;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_to
    router_timeout #(.TIMEOUT(TIMEOUT)) u_to (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld_out[p]),
      .read       (read_enb[p]),
      .empty      (fifo_empty[p]),
      .soft_reset (soft_reset[p])
    );
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= DECODE_ADDRESS;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = DECODE_ADDRESS;
    end else begin
      unique case (state)
        DECODE_ADDRESS:
          if (packet_valid) begin
            if (!addr_ok)          nxt = DROP_PACKET;
            else if (empty_x[addr]) nxt = LOAD_FIRST_DATA;
            else                   nxt = WAIT_TILL_EMPTY;
          end
        WAIT_TILL_EMPTY:
          if (p_empty) nxt = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:
          if (!p_full) nxt = LOAD_DATA;
        LOAD_DATA:
          if (p_full)            nxt = FIFO_FULL_STATE;
          else if (!packet_valid) nxt = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!p_full) nxt = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (p_full)           nxt = FIFO_FULL_STATE;
          else if (parity_done) nxt = CHECK_PARITY_ERROR;
          else if (hold_par)    nxt = LOAD_PARITY;
          else                  nxt = LOAD_DATA;
        LOAD_PARITY:
          nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          nxt = DECODE_ADDRESS;
        DROP_PACKET:
          if (!packet_valid) nxt = DECODE_ADDRESS;
        default:
          nxt = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    wr       = 1'b0;
    busy     = 1'b0;
    data_out = data_in;
    unique case (state)
      WAIT_TILL_EMPTY: busy = 1'b1;
      LOAD_FIRST_DATA: begin
        wr       = 1'b1;
        busy     = 1'b1;
        data_out = header;
      end
      LOAD_DATA:       wr = 1'b1;
      FIFO_FULL_STATE: busy = 1'b1;
      LOAD_AFTER_FULL: begin
        wr       = 1'b1;
        busy     = 1'b1;
        data_out = hold;
      end
      LOAD_PARITY:        busy = 1'b1;
      CHECK_PARITY_ERROR: busy = 1'b1;
      default: ;
    endcase
  end

  // A full FIFO or a flush of the target port always wins over a write
  assign wr_q = wr && !p_full && !abort;

  always_comb begin
    we_x       = '0;
    we_x[port] = wr_q;
  end

  assign write_enb = we_x[NUM_PORTS-1:0];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      port        <= '0;
      header      <= '0;
      hold        <= '0;
      hold_par    <= 1'b0;
      par         <= '0;
      rx_par      <= '0;
      err         <= 1'b0;
      parity_done <= 1'b0;
    end else begin
      if (hdr_ok) begin
        port        <= addr;
        header      <= data_in;
        par         <= data_in;
        err         <= 1'b0;
        parity_done <= 1'b0;
      end
      if (!abort) begin
        if (state == LOAD_DATA) begin
          if (p_full) begin
            hold     <= data_in;
            hold_par <= !packet_valid;
          end else if (packet_valid) begin
            par <= par ^ data_in;
          end else begin
            rx_par <= data_in;
          end
        end
        if (state == LOAD_AFTER_FULL && !p_full) begin
          if (hold_par) rx_par <= hold;
          else          par    <= par ^ hold;
        end
        if (state == LOAD_PARITY)        parity_done <= 1'b1;
        if (state == CHECK_PARITY_ERROR) err <= (par != rx_par);
      end
    end
  end

endmodule

// File: tb/tb_router_ctrl_np.sv
// Directed self-checking bench for router_ctrl_np (3 ports, 8-bit data).
// Writes are logged by a monitor and compared against hand-computed bytes.
module tb_router_ctrl_np;

  logic       clock = 1'b0;
  logic       resetn;
  logic       packet_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full, fifo_empty, read_enb;
  logic [2:0] write_enb, vld_out, soft_reset;
  logic [7:0] data_out;
  logic       busy, err, parity_done;

  int n_chk  = 0;
  int n_fail = 0;
  int viol   = 0;
  logic [10:0] wq[$];
  logic [2:0]  sr_any;

  router_ctrl_np #(.NUM_PORTS(3), .DATA_WIDTH(8), .TIMEOUT(30)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .packet_valid (packet_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .read_enb     (read_enb),
    .write_enb    (write_enb),
    .data_out     (data_out),
    .busy         (busy),
    .err          (err),
    .parity_done  (parity_done),
    .vld_out      (vld_out),
    .soft_reset   (soft_reset)
  );

  always #5 clock = ~clock;

  // Outputs are stable mid-low-phase; log every accepted write there
  always @(negedge clock) begin
    #2;
    if (resetn) begin
      if ((write_enb & fifo_full) != 3'b0) viol++;
      if (write_enb != 3'b0) wq.push_back({write_enb, data_out});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input string tag, input logic [2:0] we,
                        input logic [7:0] d);
    logic [10:0] e;
    e = 11'h7ff;
    if (wq.size() > 0) e = wq.pop_front();
    chk(tag, {21'd0, e}, {21'd0, we, d});
  endtask

  // Source model: present a byte, hold it while busy, consume on a non-busy edge
  task automatic send(input logic pv, input logic [7:0] d);
    int g;
    packet_valid = pv;
    data_in      = d;
    #1;
    g = 0;
    while (busy && g < 50) begin
      @(negedge clock);
      #1;
      g++;
    end
    if (g >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    packet_valid = 1'b0;
    data_in      = 8'h00;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    resetn       = 1'b0;
    packet_valid = 1'b0;
    data_in      = 8'h00;
    fifo_full    = 3'b000;
    fifo_empty   = 3'b111;
    read_enb     = 3'b000;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_we", {29'd0, write_enb}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_pdone", {31'd0, parity_done}, 32'd0);
    chk("rst_sr", {29'd0, soft_reset}, 32'd0);
    chk("rst_vld", {29'd0, vld_out}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Good packet to port 1
    send(1'b1, 8'h05);
    send(1'b1, 8'h11);
    send(1'b1, 8'h22);
    send(1'b0, 8'h36);
    idle(4);
    chk("p1_nwr", wq.size(), 32'd4);
    exp_wr("p1_w0", 3'b010, 8'h05);
    exp_wr("p1_w1", 3'b010, 8'h11);
    exp_wr("p1_w2", 3'b010, 8'h22);
    exp_wr("p1_w3", 3'b010, 8'h36);
    chk("p1_err", {31'd0, err}, 32'd0);
    chk("p1_pdone", {31'd0, parity_done}, 32'd1);

    // Invalid address 3 is dropped silently
    packet_valid = 1'b1;
    data_in      = 8'h03;
    #1;
    chk("drop_busy0", {31'd0, busy}, 32'd0);
    @(negedge clock);
    data_in = 8'haa;
    #1;
    chk("drop_busy1", {31'd0, busy}, 32'd0);
    @(negedge clock);
    data_in = 8'hbb;
    #1;
    chk("drop_busy2", {31'd0, busy}, 32'd0);
    @(negedge clock);
    packet_valid = 1'b0;
    data_in      = 8'hcc;
    #1;
    chk("drop_busy3", {31'd0, busy}, 32'd0);
    idle(3);
    chk("drop_nwr", wq.size(), 32'd0);
    chk("drop_keep_pdone", {31'd0, parity_done}, 32'd1);

    // Port 0 goes full on the 2nd payload byte for 3 cycles
    send(1'b1, 8'h08);
    send(1'b1, 8'ha1);
    packet_valid = 1'b1;
    data_in      = 8'hb2;
    fifo_full    = 3'b001;
    #1;
    chk("full_nowr", {29'd0, write_enb}, 32'd0);
    @(negedge clock);
    data_in = 8'hc3;
    #1;
    chk("full_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    @(negedge clock);
    fifo_full = 3'b000;
    send(1'b1, 8'hc3);
    send(1'b0, 8'hd8);
    idle(4);
    chk("full_nwr", wq.size(), 32'd5);
    exp_wr("full_w0", 3'b001, 8'h08);
    exp_wr("full_w1", 3'b001, 8'ha1);
    exp_wr("full_w2", 3'b001, 8'hb2);
    exp_wr("full_w3", 3'b001, 8'hc3);
    exp_wr("full_w4", 3'b001, 8'hd8);
    chk("full_err", {31'd0, err}, 32'd0);

    // Wrong parity sets err; next valid header clears it
    send(1'b1, 8'h04);
    #1;
    chk("hdr_clr_pdone", {31'd0, parity_done}, 32'd0);
    send(1'b1, 8'h01);
    send(1'b0, 8'h00);
    idle(4);
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_pdone", {31'd0, parity_done}, 32'd1);
    send(1'b1, 8'h09);
    #1;
    chk("bad_err_clr", {31'd0, err}, 32'd0);
    send(1'b0, 8'h09);
    idle(4);
    chk("hdr_only_err", {31'd0, err}, 32'd0);
    wq.delete();

    // Port 1 watchdog: a read restarts the count
    fifo_empty = 3'b101;
    sr_any     = 3'b000;
    #1;
    chk("vld_out", {29'd0, vld_out}, 32'h2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      sr_any = sr_any | soft_reset;
    end
    read_enb = 3'b010;
    @(negedge clock);
    read_enb = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      sr_any = sr_any | soft_reset;
    end
    chk("to_read_clr", {29'd0, sr_any}, 32'd0);
    repeat (10) @(negedge clock);
    #1;
    chk("to_p1_pulse", {29'd0, soft_reset}, 32'h2);
    fifo_empty = 3'b111;
    @(negedge clock);

    // Port 2 watchdog aborts a packet stuck waiting for that port
    fifo_empty   = 3'b011;
    packet_valid = 1'b1;
    data_in      = 8'h02;
    sr_any       = 3'b000;
    @(negedge clock);
    data_in = 8'h55;
    #1;
    chk("to_wait_busy", {31'd0, busy}, 32'd1);
    sr_any = sr_any | soft_reset;
    for (int i = 2; i < 30; i++) begin
      @(negedge clock);
      sr_any = sr_any | soft_reset;
    end
    chk("to_early", {29'd0, sr_any}, 32'd0);
    @(negedge clock);
    #1;
    chk("to_p2_pulse", {29'd0, soft_reset}, 32'h4);
    chk("to_abort_nowr", {29'd0, write_enb}, 32'd0);
    packet_valid = 1'b0;
    data_in      = 8'h00;
    @(negedge clock);
    #1;
    chk("to_pulse_end", {29'd0, soft_reset}, 32'd0);
    chk("to_decode", {31'd0, busy}, 32'd0);
    chk("to_err_keep", {31'd0, err}, 32'd0);
    fifo_empty = 3'b111;
    idle(2);
    chk("to_nwr", wq.size(), 32'd0);
    send(1'b1, 8'h06);
    send(1'b0, 8'h06);
    idle(4);
    exp_wr("rec_w0", 3'b100, 8'h06);
    exp_wr("rec_w1", 3'b100, 8'h06);
    chk("rec_err", {31'd0, err}, 32'd0);

    // Reset in the middle of LOAD_DATA
    send(1'b1, 8'h0c);
    send(1'b1, 8'h11);
    wq.delete();
    resetn       = 1'b0;
    packet_valid = 1'b1;
    data_in      = 8'h22;
    @(negedge clock);
    packet_valid = 1'b0;
    data_in      = 8'h00;
    #1;
    chk("mrst_we", {29'd0, write_enb}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_err", {31'd0, err}, 32'd0);
    chk("mrst_pdone", {31'd0, parity_done}, 32'd0);
    chk("mrst_sr", {29'd0, soft_reset}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    send(1'b1, 8'h01);
    send(1'b0, 8'h01);
    idle(4);
    chk("mrst_nwr", wq.size(), 32'd2);
    exp_wr("mrst_w0", 3'b010, 8'h01);
    exp_wr("mrst_w1", 3'b010, 8'h01);
    chk("mrst_pdone2", {31'd0, parity_done}, 32'd1);

    chk("no_write_full", viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
